stripe_run_detector: RTL

STRIPE_RUN_DETECTOR -- requirements
Module: stripe_run_detector

---
 rtl/stripe_run_if.sv | 36 +++
 rtl/stripe_run_detector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/stripe_run_if.sv
// Handshake and BRAM read bus between the stripe run detector and its environment.
// Optional row_hits signal exists only when STRIPE_ROW_HITS_EN is defined.
interface stripe_run_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 2,
  parameter int CNT_W  = 8
);
  logic              valid_to_read;
  logic [ADDR_W-1:0] bram_addr;
  logic [PIX_W-1:0]  bram_data;
  logic              busy;
  logic              detection_valid;
  logic              crossing_detected;
  logic [CNT_W-1:0]  stripe_count;
`ifdef STRIPE_ROW_HITS_EN
  logic [CNT_W-1:0]  row_hits;

  modport master (
    output valid_to_read, bram_data,
    input  bram_addr, busy, detection_valid, crossing_detected, stripe_count, row_hits
  );
  modport slave (
    input  valid_to_read, bram_data,
    output bram_addr, busy, detection_valid, crossing_detected, stripe_count, row_hits
  );
`else
  modport master (
    output valid_to_read, bram_data,
    input  bram_addr, busy, detection_valid, crossing_detected, stripe_count
  );
  modport slave (
    input  valid_to_read, bram_data,
    output bram_addr, busy, detection_valid, crossing_detected, stripe_count
  );
`endif
endinterface

// File: rtl/stripe_run_detector.sv
// Scans subsampled image rows from BRAM, counts legal-width foreground stripes per row and
// flags a crossing after MIN_ROWS consecutive qualifying rows. Macro STRIPE_ROW_HITS_EN adds row_hits.
module stripe_run_detector #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int PIX_W       = 2,
  parameter int FG_VALUE    = 1,
  parameter int ROW_STEP    = 4,
  parameter int MIN_RUN     = 8,
  parameter int MAX_RUN     = 200,
  parameter int MIN_STRIPES = 3,
  parameter int MIN_ROWS    = 4,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  stripe_run_if.slave  bus
);
  localparam int ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
  localparam int NROWS  = (IMG_HEIGHT + ROW_STEP - 1) / ROW_STEP;
  localparam int XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW     = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int RUN_W  = $clog2(MAX_RUN + 2);

  localparam logic [XW-1:0]     X_LAST      = XW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]     ROW_LAST    = RW'(NROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_SKIP    = ADDR_W'((ROW_STEP - 1) * IMG_WIDTH + 1);
  localparam logic [RUN_W-1:0]  RUN_MIN     = RUN_W'(MIN_RUN);
  localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0]  RUN_SAT     = RUN_W'(MAX_RUN + 1);
  localparam logic [CNT_W-1:0]  STRIPES_MIN = CNT_W'(MIN_STRIPES);
  localparam logic [CNT_W-1:0]  ROWS_MIN    = CNT_W'(MIN_ROWS);
  localparam logic [PIX_W-1:0]  FG_PIX      = PIX_W'(FG_VALUE);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t            state;
  logic              start_prev;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x;
  logic [RW-1:0]     row;
  logic              vld_p0, xlast_p0;
  logic [RUN_W-1:0]  run;
  logic [CNT_W-1:0]  row_stripes, consec, stripe_count;
  logic              busy, detection_valid, crossing_detected;
`ifdef STRIPE_ROW_HITS_EN
  logic [CNT_W-1:0]  row_hits;
`endif

  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
    return (r >= RUN_SAT) ? RUN_SAT : r + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Stage p1: classify the returned pixel, aligned with vld_p0/xlast_p0
  logic             fg, closing, stripe_hit, row_qual;
  logic [RUN_W-1:0] run_up, closed_len;
  logic [CNT_W-1:0] row_stripes_new, consec_new;

  always_comb begin
    fg              = (bus.bram_data == FG_PIX);
    run_up          = run_inc(run);
    // a foreground pixel only closes its run when it is the last one in the row
    closing         = fg ? xlast_p0 : (run != '0);
    closed_len      = fg ? run_up : run;
    stripe_hit      = closing && (closed_len >= RUN_MIN) && (closed_len <= RUN_MAX);
    row_stripes_new = stripe_hit ? cnt_inc(row_stripes) : row_stripes;
    row_qual        = (row_stripes_new >= STRIPES_MIN);
    consec_new      = row_qual ? cnt_inc(consec) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      start_prev        <= 1'b1;   // a level already high at reset release is not a start
      addr              <= '0;
      x                 <= '0;
      row               <= '0;
      vld_p0            <= 1'b0;
      xlast_p0          <= 1'b0;
      run               <= '0;
      row_stripes       <= '0;
      consec            <= '0;
      stripe_count      <= '0;
      busy              <= 1'b0;
      detection_valid   <= 1'b0;
      crossing_detected <= 1'b0;
`ifdef STRIPE_ROW_HITS_EN
      row_hits          <= '0;
`endif
    end else begin
      start_prev      <= bus.valid_to_read;
      detection_valid <= 1'b0;
      // Stage p0: address issued this cycle, its data returns next cycle
      vld_p0          <= (state == SCAN);
      xlast_p0        <= (state == SCAN) && (x == X_LAST);

      if (vld_p0) begin
        if (xlast_p0) begin
          run         <= '0;
          row_stripes <= '0;
          consec      <= consec_new;
          if (row_stripes_new > stripe_count) stripe_count <= row_stripes_new;
          if (consec_new >= ROWS_MIN) crossing_detected <= 1'b1;
`ifdef STRIPE_ROW_HITS_EN
          if (row_qual) row_hits <= cnt_inc(row_hits);
`endif
        end else begin
          run         <= fg ? run_up : '0;
          row_stripes <= row_stripes_new;
        end
      end

      case (state)
        IDLE: begin
          if (bus.valid_to_read && !start_prev) begin
            state             <= SCAN;
            busy              <= 1'b1;
            addr              <= '0;
            x                 <= '0;
            row               <= '0;
            run               <= '0;
            row_stripes       <= '0;
            consec            <= '0;
            stripe_count      <= '0;
            crossing_detected <= 1'b0;
`ifdef STRIPE_ROW_HITS_EN
            row_hits          <= '0;
`endif
          end
        end
        SCAN: begin
          if (x == X_LAST) begin
            x <= '0;
            if (row == ROW_LAST) begin
              state <= FLUSH;
            end else begin
              row  <= row + 1'b1;
              addr <= addr + ROW_SKIP;
            end
          end else begin
            x    <= x + 1'b1;
            addr <= addr + 1'b1;
          end
        end
        FLUSH: state <= DONE;
        DONE: begin
          detection_valid <= 1'b1;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bram_addr         = addr;
  assign bus.busy              = busy;
  assign bus.detection_valid   = detection_valid;
  assign bus.crossing_detected = crossing_detected;
  assign bus.stripe_count      = stripe_count;
`ifdef STRIPE_ROW_HITS_EN
  assign bus.row_hits          = row_hits;
`endif
endmodule
